// File: rtl/llc_pipe_arb.sv
// LLC head input select: source 0 has fixed priority, 1..N_SRC-1 round-robin, credit-limited.
// Optional LLC_ARB_STARVE_GUARD_EN lets round-robin through after STARVE_LIMIT back-to-back source-0 grants.
module llc_pipe_arb #(
  parameter int DATA_WIDTH   = 32,
  parameter int N_SRC        = 4,
  parameter int MAX_INFLIGHT = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_SRC-1:0]                  src_valid,
  input  logic [N_SRC*DATA_WIDTH-1:0]       src_data,
  output logic [N_SRC-1:0]                  src_ready,
  input  logic                              ready_in,
  output logic                              valid_out,
  output logic [DATA_WIDTH-1:0]             data_out,
  output logic [$clog2(N_SRC)-1:0]          src_id_out,
  input  logic                              done_in,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_cnt,
  output logic                              err_out
);

  localparam int SW = $clog2(N_SRC);
  localparam int CW = $clog2(MAX_INFLIGHT+1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_INFLIGHT);

  logic [SW-1:0]    r_rr_ptr;
  logic [CW-1:0]    r_cnt;
  logic             r_err;

  logic             w_credit_ok;
  logic [N_SRC-1:0] w_elig;
  logic             w_rr_found;
  logic [SW-1:0]    w_rr_idx;
  logic             w_s0_mask;
  logic             w_pick0;
  logic             w_gnt_vld;
  logic [SW-1:0]    w_gnt_idx;
  logic             w_hs_cred;

  // Source 0 bypasses the credit check so responses can always drain the pipeline.
  assign w_credit_ok = (r_cnt < MAX_C);
  assign w_elig      = src_valid & {{(N_SRC-1){w_credit_ok}}, 1'b1};

  always_comb begin : p_rr_scan
    logic [SW-1:0] idx;
    idx        = '0;
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int off = 0; off < N_SRC-1; off++) begin
      idx = SW'(((int'(r_rr_ptr) - 1 + off) % (N_SRC-1)) + 1);
      if (!w_rr_found && w_elig[idx]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = idx;
      end
    end
  end

`ifdef LLC_ARB_STARVE_GUARD_EN
  localparam int STW = $clog2(STARVE_LIMIT+1);
  localparam logic [STW-1:0] SL_C = STW'(STARVE_LIMIT);

  logic [STW-1:0] r_starve;

  assign w_s0_mask = (r_starve == SL_C) && w_rr_found;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve <= '0;
    end else if (w_hs_cred) begin
      r_starve <= '0;
    end else if (w_gnt_vld && w_rr_found) begin
      r_starve <= r_starve + 1'b1;
    end
  end
`else
  // Always false; keeps STARVE_LIMIT referenced when the guard is compiled out.
  assign w_s0_mask = (STARVE_LIMIT < 0);
`endif

  assign w_pick0   = w_elig[0] & ~w_s0_mask;
  assign w_gnt_vld = rst & ready_in & (w_pick0 | w_rr_found);
  assign w_gnt_idx = w_pick0 ? '0 : w_rr_idx;
  assign w_hs_cred = w_gnt_vld & ~w_pick0;

  always_comb begin
    src_ready  = '0;
    data_out   = '0;
    valid_out  = w_gnt_vld;
    src_id_out = w_gnt_vld ? w_gnt_idx : '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (w_gnt_vld && (w_gnt_idx == SW'(i))) begin
        src_ready[i] = 1'b1;
        data_out     = src_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr <= SW'(1);
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_hs_cred) begin
        r_rr_ptr <= (w_gnt_idx == SW'(N_SRC-1)) ? SW'(1) : w_gnt_idx + 1'b1;
      end
      // A grant and a retire in the same cycle cancel out.
      case ({w_hs_cred, done_in})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01: begin
          if (r_cnt == '0) r_err <= 1'b1;
          else             r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign inflight_cnt = r_cnt;
  assign err_out      = r_err;

endmodule

// File: doc/llc_pipe_arb.md
Name: llc_pipe_arb

Overview:
- Input-select stage at the head of the pipelined LLC. Feeds the first pipeline register through a valid-ready handshake.
- Picks one of N_SRC request sources per cycle:
  - Source 0 is the response/recall channel and has fixed highest priority.
  - Sources 1..N_SRC-1 share round-robin arbitration.
- Enforces a credit limit on in-flight non-response transactions, so the pipeline never holds more than MAX_INFLIGHT of them.

Parameters:
- DATA_WIDTH, 32, width of one source packet.
- N_SRC, 4, number of sources (minimum 2); index 0 is the priority channel.
- MAX_INFLIGHT, 8, maximum outstanding credited transactions (minimum 1).
- STARVE_LIMIT, 16, consecutive source-0 grants before forced round-robin service (used only with the optional feature).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- src_valid  input  N_SRC  per-source request valid.
- src_data  input  N_SRC*DATA_WIDTH  per-source packets; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- src_ready  output  N_SRC  one-hot grant; the source is consumed on src_valid[i] && src_ready[i].
- ready_in  input  1  downstream pipeline register can accept.
- valid_out  output  1  selected packet valid toward the pipeline register.
- data_out  output  DATA_WIDTH  selected packet.
- src_id_out  output  $clog2(N_SRC)  index of the selected source.
- done_in  input  1  one credited transaction retired; returns one credit.
- inflight_cnt  output  $clog2(MAX_INFLIGHT+1)  credits currently consumed.
- err_out  output  1  sticky error flag: done_in arrived with inflight_cnt==0.

Behaviour:
- Zero latency; selection is combinational from the current inputs and state.
  - valid_out is asserted only when ready_in==1, so downstream never sees valid without ready.
  - Exactly one src_ready bit is high, and only when valid_out==1; data_out equals the granted source's packet.
- Eligibility:
  - Source 0 is eligible whenever src_valid[0]. It neither checks nor consumes credits, which prevents deadlock because responses retire transactions.
  - Source i≥1 is eligible when src_valid[i] && inflight_cnt < MAX_INFLIGHT.
- Selection:
  - If source 0 is eligible, it wins.
  - Otherwise, scan sources rr_ptr, rr_ptr+1, … wrapping from N_SRC-1 back to 1; the first eligible source wins.
  - No eligible source: valid_out=0, src_ready=0, data_out=0, src_id_out=0.
- rr_ptr:
  - Reset value 1.
  - On a handshake with source k≥1, rr_ptr becomes k+1, wrapping to 1 after N_SRC-1.
  - Unchanged on a source-0 grant or an idle cycle.
- inflight_cnt:
  - Reset value 0.
  - +1 on a handshake with a source ≥1; -1 on done_in.
  - Both in the same cycle: unchanged.
  - done_in at 0 with no simultaneous grant: count stays 0 and err_out sets.
  - Never exceeds MAX_INFLIGHT.
- err_out: reset 0; cleared only by reset.
- Reset values: src_ready=0, valid_out=0, data_out=0, src_id_out=0, inflight_cnt=0, err_out=0, rr_ptr=1.
- Mid-operation reset: all state returns to reset values immediately; outstanding credits are discarded.
- ready_in low: no grant, no state change except credit return via done_in.
- src_valid may drop without a handshake (no stability requirement); the arbiter holds no packet state.

Optional Feature:
- Macro: LLC_ARB_STARVE_GUARD_EN.
- With the macro, a starve counter of width $clog2(STARVE_LIMIT+1) runs as follows:
  - Increments on each source-0 handshake made while some source ≥1 was eligible.
  - Clears on any handshake with a source ≥1 and on reset.
  - When it equals STARVE_LIMIT and a source ≥1 is eligible, source 0 is masked for that cycle, so the round-robin winner is granted; the counter then clears.
- Without the macro: strict source-0 priority, and no counter logic is present.

Test Plan:
- Reset, then src_valid=4'b1111 with ready_in=1 → src_ready=0001 on every cycle; rr_ptr stays 1; inflight_cnt stays 0.
- src_valid=4'b1110, ready_in=1, no done_in, MAX_INFLIGHT=8 → grant sequence 1,2,3,1,2,3,1,2; inflight_cnt reaches 8; the next cycle has valid_out=0.
- At inflight_cnt=8, pulse done_in for one cycle with src_valid=4'b0100 → the next cycle grants source 2; inflight_cnt 8→7→8.
- Grant to source 3 together with done_in in the same cycle at inflight_cnt=5 → inflight_cnt stays 5; rr_ptr=1.
- done_in with inflight_cnt=0 and no grant → err_out=1 and stays 1 until rst is asserted low.
- With LLC_ARB_STARVE_GUARD_EN, STARVE_LIMIT=16, src_valid=4'b0011 constant → 16 grants to source 0, then 1 grant to source 1, repeating. Without the macro → source 0 is granted forever.
